// File: rtl/usb_fs_out_sequencer_if.sv
// usb_fs_out_sequencer_if: receive events, OUT endpoint buffer and handshake request signals
interface usb_fs_out_sequencer_if #(parameter int NUM_EP = 4);
  logic [6:0] dev_addr;
  logic rx_pkt_start;
  logic rx_pkt_end;
  logic [3:0] rx_pid;
  logic [6:0] rx_addr;
  logic [3:0] rx_endp;
  logic rx_valid_packet;
  logic rx_data_put;
  logic [7:0] rx_data;
  logic [NUM_EP-1:0] ep_ready;
  logic [NUM_EP-1:0] ep_stall;
  logic [NUM_EP-1:0] ep_sel;
  logic ep_setup;
  logic ep_data_put;
  logic [7:0] ep_data;
  logic ep_commit;
  logic ep_abort;
  logic hs_req;
  logic [3:0] hs_pid;
  logic hs_grant;
  modport master (
    input dev_addr, rx_pkt_start, rx_pkt_end, rx_pid, rx_addr, rx_endp, rx_valid_packet,
    input rx_data_put, rx_data, ep_ready, ep_stall, hs_grant,
    output ep_sel, ep_setup, ep_data_put, ep_data, ep_commit, ep_abort, hs_req, hs_pid
  );
  modport slave (
    output dev_addr, rx_pkt_start, rx_pkt_end, rx_pid, rx_addr, rx_endp, rx_valid_packet,
    output rx_data_put, rx_data, ep_ready, ep_stall, hs_grant,
    input ep_sel, ep_setup, ep_data_put, ep_data, ep_commit, ep_abort, hs_req, hs_pid
  );
endinterface

// File: rtl/usb_fs_out_sequencer.sv
// usb_fs_out_sequencer: full-speed OUT/SETUP token -> data -> handshake sequencer.
// Define USB_OUT_SEQ_MAXPKT_CHECK_EN to abort packets longer than 66 bytes (babble).
module usb_fs_out_sequencer #(
  parameter int NUM_EP = 4,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic reset,
  usb_fs_out_sequencer_if.master bus
);
  localparam int EW = NUM_EP > 1 ? $clog2(NUM_EP) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] PID_OUT = 4'b0001, PID_SETUP = 4'b1101, PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011, PID_ACK = 4'b0010, PID_NAK = 4'b1010, PID_STALL = 4'b1110;
  typedef enum logic [1:0] {IDLE, WAIT_DATA, DATA, HS} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [EW-1:0] ep_q, tok_ep;
  logic [NUM_EP-1:0] tog_q, sel_q;
  logic ready_q, setup_q, put_q, commit_q, abort_q, hs_req_q;
  logic [7:0] data_q;
  logic [3:0] hs_pid_q;
  logic latch, is_data, stall, elig, fwd, babble, do_commit;
  assign tok_ep = bus.rx_endp[EW-1:0];
  assign latch = state_q != HS && bus.rx_pkt_end && bus.rx_valid_packet &&
                 (bus.rx_pid == PID_OUT || bus.rx_pid == PID_SETUP) &&
                 bus.rx_addr == bus.dev_addr && int'(bus.rx_endp) < NUM_EP;
  assign is_data = bus.rx_pid == PID_DATA0 || bus.rx_pid == PID_DATA1;
  assign stall = bus.ep_stall[ep_q];
  assign elig = setup_q || (ready_q && !stall);
  assign do_commit = setup_q ? bus.rx_pid == PID_DATA0 : !stall && ready_q && bus.rx_pid[3] == tog_q[ep_q];
`ifdef USB_OUT_SEQ_MAXPKT_CHECK_EN
  logic [6:0] bcnt_q;
  assign fwd = elig && bus.rx_data_put && bcnt_q < 7'd66;
  assign babble = bcnt_q > 7'd66 || (bcnt_q == 7'd66 && elig && bus.rx_data_put);
  // counts every eligible byte so the 67th marks the packet as babble
  always_ff @(posedge clk or posedge reset)
    if (reset) bcnt_q <= '0;
    else if (latch) bcnt_q <= '0;
    else if (state_q == DATA && elig && bus.rx_data_put && bcnt_q != 7'h7f) bcnt_q <= bcnt_q + 7'd1;
`else
  assign fwd = elig && bus.rx_data_put;
  assign babble = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ep_q <= '0;
      tog_q <= '0;
      sel_q <= '0;
      ready_q <= 1'b0;
      setup_q <= 1'b0;
      put_q <= 1'b0;
      data_q <= '0;
      commit_q <= 1'b0;
      abort_q <= 1'b0;
      hs_req_q <= 1'b0;
      hs_pid_q <= '0;
    end else begin
      put_q <= state_q == DATA && fwd;
      data_q <= state_q == DATA && fwd ? bus.rx_data : data_q;
      commit_q <= 1'b0;
      abort_q <= 1'b0;
      // a token seen before any data (its start already moved us to DATA) restarts the wait
      if (latch) begin
        state_q <= WAIT_DATA;
        cnt_q <= '0;
        ep_q <= tok_ep;
        sel_q <= NUM_EP'(1) << tok_ep;
        setup_q <= bus.rx_pid == PID_SETUP;
        ready_q <= bus.ep_ready[tok_ep];
      end else
        case (state_q)
          WAIT_DATA:
            if (bus.rx_pkt_start) state_q <= DATA;
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
              state_q <= IDLE;
              sel_q <= '0;
              setup_q <= 1'b0;
            end else cnt_q <= cnt_q + 1'b1;
          DATA:
            if (bus.rx_pkt_end) begin
              if (!bus.rx_valid_packet || !is_data || babble) begin
                abort_q <= 1'b1;
                state_q <= IDLE;
                sel_q <= '0;
                setup_q <= 1'b0;
              end else begin
                state_q <= HS;
                hs_req_q <= 1'b1;
                hs_pid_q <= (setup_q || (!stall && ready_q)) ? PID_ACK : stall ? PID_STALL : PID_NAK;
                commit_q <= do_commit;
                abort_q <= !do_commit;
                if (do_commit) tog_q[ep_q] <= setup_q || !tog_q[ep_q];
              end
            end
          HS:
            if (bus.hs_grant || bus.rx_pkt_start) begin
              state_q <= IDLE;
              hs_req_q <= 1'b0;
              sel_q <= '0;
              setup_q <= 1'b0;
            end
          default: ;
        endcase
    end
  assign bus.ep_sel = sel_q;
  assign bus.ep_setup = setup_q;
  assign bus.ep_data_put = put_q;
  assign bus.ep_data = data_q;
  assign bus.ep_commit = commit_q;
  assign bus.ep_abort = abort_q;
  assign bus.hs_req = hs_req_q;
  assign bus.hs_pid = hs_pid_q;
endmodule

// File: tb/tb_usb_fs_out_sequencer.sv
// tb_usb_fs_out_sequencer: directed and random OUT/SETUP transactions against a transaction-level model
module tb_usb_fs_out_sequencer;
  localparam logic [3:0] OUT = 4'b0001, SETUP = 4'b1101, DATA0 = 4'b0011, DATA1 = 4'b1011,
    ACK = 4'b0010, NAK = 4'b1010, STALL = 4'b1110;
  localparam logic [6:0] DEV = 7'd5;
`ifdef USB_OUT_SEQ_MAXPKT_CHECK_EN
  localparam int MAXB = 66;
`else
  localparam int MAXB = 1 << 20;
`endif
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  usb_fs_out_sequencer_if #(.NUM_EP(4)) bus ();
  usb_fs_out_sequencer #(.NUM_EP(4), .TIMEOUT(1024)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_chk = 0, n_fail = 0;
  int n_commit = 0, n_abort = 0, n_both = 0;
  logic [7:0] obs_q[$];
  logic [7:0] sent_q[$];
  bit tog[4];
  logic [3:0] r_tok, r_dp, r_ep;
  logic [6:0] r_ad;
  int base_c, base_a;
  always @(negedge clk) begin
    if (bus.ep_data_put) obs_q.push_back(bus.ep_data);
    if (bus.ep_commit) n_commit++;
    if (bus.ep_abort) n_abort++;
    if (bus.ep_commit && bus.ep_abort) n_both++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_end(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp, input bit valid);
    bus.rx_pkt_end = 1'b1;
    bus.rx_pid = pid;
    bus.rx_addr = addr;
    bus.rx_endp = endp;
    bus.rx_valid_packet = valid;
  endtask
  task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
    bus.rx_pkt_start = 1'b1;
    cyc();
    bus.rx_pkt_start = 1'b0;
    set_end(pid, addr, endp, 1'b1);
    cyc();
    bus.rx_pkt_end = 1'b0;
  endtask
  task automatic send_data(input logic [3:0] pid, input int n, input bit valid, input bit same);
    sent_q.delete();
    bus.rx_pkt_start = 1'b1;
    cyc();
    bus.rx_pkt_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.rx_data_put = 1'b1;
      bus.rx_data = 8'($urandom);
      sent_q.push_back(bus.rx_data);
      if (same && i == n - 1) set_end(pid, 7'd0, 4'd0, valid);
      cyc();
    end
    bus.rx_data_put = 1'b0;
    if (!(same && n > 0)) begin
      set_end(pid, 7'd0, 4'd0, valid);
      cyc();
    end
    bus.rx_pkt_end = 1'b0;
  endtask
  task automatic txn(input logic [3:0] tok, input logic [6:0] addr, input logic [3:0] endp, input logic [3:0] dpid,
                     input int n, input bit dvalid, input bit same, input logic [3:0] rdy, input logic [3:0] stl,
                     input int hold);
    bit tok_ok, setup, elig, babble, e_commit, e_abort, e_hs;
    logic [3:0] e_pid;
    logic [1:0] e;
    int e_puts, base, bc, ba;
    e = endp[1:0];
    tok_ok = (tok == OUT || tok == SETUP) && addr == DEV && endp < 4;
    setup = tok == SETUP;
    elig = tok_ok && (setup || (rdy[e] && !stl[e]));
    e_puts = !elig ? 0 : (n > MAXB ? MAXB : n);
    babble = elig && n > MAXB;
    e_commit = 0;
    e_abort = 0;
    e_hs = 0;
    e_pid = ACK;
    if (tok_ok) begin
      if (!dvalid || !(dpid == DATA0 || dpid == DATA1) || babble) e_abort = 1;
      else begin
        e_hs = 1;
        if (setup) begin
          e_commit = dpid == DATA0;
          if (e_commit) tog[e] = 1;
        end else if (stl[e]) e_pid = STALL;
        else if (!rdy[e]) e_pid = NAK;
        else if ((dpid == DATA1) == tog[e]) begin
          e_commit = 1;
          tog[e] = !tog[e];
        end
        e_abort = !e_commit;
      end
    end
    bus.ep_ready = rdy;
    bus.ep_stall = stl;
    base = obs_q.size();
    bc = n_commit;
    ba = n_abort;
    send_token(tok, addr, endp);
    @(negedge clk);
    #1;
    check("ep_sel_token", bus.ep_sel, tok_ok ? 4'b0001 << e : 4'b0000);
    check("ep_setup", bus.ep_setup, tok_ok && setup);
    cyc();
    send_data(dpid, n, dvalid, same);
    @(negedge clk);
    #1;
    check("hs_req", bus.hs_req, e_hs);
    if (e_hs) check("hs_pid", bus.hs_pid, e_pid);
    repeat (hold) @(negedge clk);
    #1;
    if (hold > 0) begin
      check("hs_req_held", bus.hs_req, e_hs);
      check("hs_pid_held", bus.hs_pid, e_pid);
    end
    bus.hs_grant = e_hs;
    @(posedge clk);
    #1;
    bus.hs_grant = 1'b0;
    @(negedge clk);
    #1;
    check("hs_req_done", bus.hs_req, 0);
    check("ep_sel_idle", bus.ep_sel, 0);
    check("commit", n_commit - bc, e_commit);
    check("abort", n_abort - ba, e_abort);
    check("puts", obs_q.size() - base, e_puts);
    for (int i = 0; i < e_puts && base + i < obs_q.size(); i++) check("byte", obs_q[base + i], sent_q[i]);
  endtask
  initial begin
    reset = 1'b1;
    bus.dev_addr = DEV;
    bus.rx_pkt_start = 0;
    bus.rx_pkt_end = 0;
    bus.rx_pid = 0;
    bus.rx_addr = 0;
    bus.rx_endp = 0;
    bus.rx_valid_packet = 0;
    bus.rx_data_put = 0;
    bus.rx_data = 0;
    bus.ep_ready = 4'hF;
    bus.ep_stall = 0;
    bus.hs_grant = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {bus.ep_sel, bus.ep_setup, bus.ep_data_put, bus.ep_data, bus.ep_commit,
                         bus.ep_abort, bus.hs_req, bus.hs_pid}, 0);
    reset = 1'b0;
    cyc();
    txn(OUT, DEV, 1, DATA0, 5, 1, 0, 4'hF, 4'h0, 0);
    txn(OUT, DEV, 1, DATA1, 5, 1, 1, 4'hF, 4'h0, 0);
    txn(OUT, DEV, 1, DATA1, 5, 1, 0, 4'hF, 4'h0, 0);
    txn(SETUP, DEV, 0, DATA0, 10, 1, 0, 4'hF, 4'h1, 0);
    txn(OUT, DEV, 0, DATA1, 4, 1, 0, 4'hF, 4'h0, 0);
    txn(OUT, DEV, 2, DATA0, 4, 1, 0, 4'hB, 4'h0, 20);
    txn(OUT, DEV, 2, DATA0, 4, 1, 0, 4'hF, 4'h4, 0);
    txn(OUT, 7'd6, 1, DATA0, 4, 1, 0, 4'hF, 4'h0, 0);
    txn(OUT, DEV, 7, DATA0, 4, 1, 0, 4'hF, 4'h0, 0);
    txn(OUT, DEV, 3, DATA0, 4, 0, 0, 4'hF, 4'h0, 0);
    txn(OUT, DEV, 1, tog[1] ? DATA1 : DATA0, 70, 1, 0, 4'hF, 4'h0, 0);
    send_token(OUT, DEV, 1);
    txn(OUT, DEV, 3, tog[3] ? DATA1 : DATA0, 3, 1, 0, 4'hF, 4'h0, 0);
    base_c = n_commit;
    base_a = n_abort;
    send_token(OUT, DEV, 1);
    @(negedge clk);
    check("to_sel_start", bus.ep_sel, 4'b0010);
    repeat (1000) @(negedge clk);
    check("to_sel_waiting", bus.ep_sel, 4'b0010);
    repeat (30) @(negedge clk);
    check("to_sel_idle", bus.ep_sel, 0);
    check("to_hs_req", bus.hs_req, 0);
    check("to_no_commit_abort", (n_commit - base_c) + (n_abort - base_a), 0);
    cyc();
    for (int k = 0; k < 16; k++) begin
      r_tok = $urandom_range(0, 3) == 0 ? SETUP : OUT;
      r_ad = $urandom_range(0, 7) == 0 ? 7'd6 : DEV;
      r_ep = $urandom_range(0, 9) == 0 ? 4'd7 : 4'($urandom_range(0, 3));
      r_dp = $urandom_range(0, 1) != 0 ? DATA1 : DATA0;
      txn(r_tok, r_ad, r_ep, r_dp, $urandom_range(2, 12), $urandom_range(0, 7) != 0,
          $urandom_range(0, 1) != 0, 4'($urandom), 4'($urandom), 0);
    end
    bus.ep_ready = 4'hF;
    bus.ep_stall = 0;
    send_token(OUT, DEV, 1);
    cyc();
    bus.rx_pkt_start = 1'b1;
    cyc();
    bus.rx_pkt_start = 1'b0;
    bus.rx_data_put = 1'b1;
    bus.rx_data = 8'hA5;
    cyc();
    check("rst_pre_sel", bus.ep_sel, 4'b0010);
    check("rst_pre_put", bus.ep_data_put, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_outs", {bus.ep_sel, bus.ep_setup, bus.ep_data_put, bus.ep_data, bus.ep_commit,
                             bus.ep_abort, bus.hs_req, bus.hs_pid}, 0);
    bus.rx_data_put = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tog = '{default: 0};
    cyc();
    txn(OUT, DEV, 1, DATA0, 4, 1, 0, 4'hF, 4'h0, 0);
    check("commit_abort_exclusive", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/usb_fs_out_sequencer.md
Name: usb_fs_out_sequencer

Overview:
- Controller for the full-speed receive path: consumes decoded packet events (clk domain) and sequences OUT/SETUP transactions as token -> data -> handshake.
- Filters by device address, routes payload bytes to one of NUM_EP OUT endpoints, and tracks per-endpoint DATA0/DATA1 toggles.
- Decides whether the payload is committed or aborted, and requests ACK/NAK/STALL from the transmit side.
- Sits between the receive decoder and the OUT endpoint buffers; it is the single owner of the receive datapath's data stream.

Parameters:
NUM_EP, 4, number of OUT endpoints (endpoint numbers 0..NUM_EP-1); tokens addressed to higher endpoints are ignored.
TIMEOUT, 1024, clk cycles to wait for a DATA packet after a matching token before returning to IDLE.

Ports:
clk  in  1  block clock; all ports synchronous to it.
reset  in  1  asynchronous, active-high reset.
dev_addr  in  7  assigned device address.
rx_pkt_start  in  1  pulse: packet started.
rx_pkt_end  in  1  pulse: packet ended; rx_pid/rx_addr/rx_endp/rx_valid_packet valid this cycle.
rx_pid  in  4  PID of the last packet.
rx_addr  in  7  token address.
rx_endp  in  4  token endpoint.
rx_valid_packet  in  1  last packet passed PID/CRC checks.
rx_data_put  in  1  pulse: rx_data valid; includes the 2 CRC bytes.
rx_data  in  8  received byte.
ep_ready  in  NUM_EP  endpoint has space for a max-size packet.
ep_stall  in  NUM_EP  endpoint halted.
ep_sel  out  NUM_EP  one-hot target endpoint; all zero when idle.
ep_setup  out  1  current transaction is SETUP.
ep_data_put  out  1  pulse: ep_data valid for ep_sel.
ep_data  out  8  forwarded byte.
ep_commit  out  1  pulse: accept buffered bytes, minus the last 2 CRC bytes.
ep_abort  out  1  pulse: discard buffered bytes.
hs_req  out  1  level: handshake requested.
hs_pid  out  4  handshake PID; held stable while hs_req is high.
hs_grant  in  1  tx accepted the request; clears hs_req on the next edge.

Behaviour:
- PID codes:
  - Tokens: OUT=0001, SETUP=1101.
  - Data: DATA0=0011, DATA1=1011.
  - Handshakes: ACK=0010, NAK=1010, STALL=1110.
- Reset values:
  - All outputs 0; state IDLE; timeout counter 0.
  - Toggle table: all endpoints expect DATA0.
- States: IDLE, WAIT_DATA, DATA, HS.
- IDLE:
  - On rx_pkt_end with all of the following, latch the endpoint, drive ep_sel one-hot, set ep_setup for SETUP, clear the counter, and go to WAIT_DATA on the next edge:
    - rx_valid_packet=1;
    - rx_pid is OUT or SETUP;
    - rx_addr==dev_addr;
    - rx_endp<NUM_EP.
  - Any other packet is ignored and the block stays in IDLE.
- WAIT_DATA:
  - The counter increments every cycle.
  - Counter reaching TIMEOUT-1 -> ep_sel and ep_setup clear, state IDLE; no handshake, no commit/abort.
  - rx_pkt_start -> DATA.
- DATA:
  - Each rx_data_put yields ep_data_put and ep_data=rx_data on the next cycle (1-cycle latency, registered).
  - Bytes are forwarded only when one of the following holds; otherwise they are dropped:
    - ep_setup=1;
    - the endpoint is ready and not stalled.
- On rx_pkt_end in DATA, evaluate the following in priority order:
  1. rx_valid_packet=0 or rx_pid not DATA0/DATA1 -> ep_abort, no handshake, IDLE.
  2. SETUP transaction -> ACK regardless of stall/ready.
     - If rx_pid=DATA0: ep_commit and the endpoint toggle is set to expect DATA1.
     - Otherwise: ep_abort.
  3. ep_stall[ep]=1 -> ep_abort, STALL.
  4. ep_ready[ep]=0 (sampled at token time) -> ep_abort, NAK.
  5. Data PID toggle equals the expected toggle -> ep_commit, ACK, toggle flipped.
  6. Data PID toggle differs from the expected toggle (retransmitted duplicate) -> ep_abort, ACK, toggle unchanged.
- Commit/abort and hs_req assert together, one cycle after rx_pkt_end; the state then goes to HS (or IDLE when there is no handshake).
- HS:
  - hs_req and hs_pid are held until hs_grant.
  - On the grant edge: hs_req=0, ep_sel=0, ep_setup=0, state IDLE.
- rx_pkt_start seen in HS: the pending handshake is dropped, ep_abort is not re-issued, and the state goes to IDLE.
- Token arriving in WAIT_DATA (rx_pkt_end with a token PID before any data): the new token replaces the old one; the state restarts WAIT_DATA with the new endpoint.
- rx_data_put and rx_pkt_end in the same cycle: the byte is forwarded, then the end-of-packet decision follows in order.
- ep_commit and ep_abort are never high together; at most one fires per transaction.
- Asynchronous reset mid-transaction:
  - Outputs drop immediately.
  - No commit is issued; endpoints must treat reset as abort.

Optional Feature:
- Macro: USB_OUT_SEQ_MAXPKT_CHECK_EN.
- When defined:
  - A per-transaction byte counter (7 bits, saturating) counts forwarded bytes.
  - Exceeding 66 bytes (64 payload + 2 CRC) forces ep_abort at packet end with no handshake (babble).
  - Further bytes beyond 66 are not forwarded.
- When undefined: no counter, and packets of any length are forwarded.

Test Plan:
- OUT addr=dev_addr=5, endp=1; DATA0 with 3 bytes + 2 CRC bytes -> ep_sel=0010, 5 ep_data_put, ep_commit, hs_pid=ACK; repeat with DATA1 -> ACK; a second DATA1 -> ep_abort + ACK.
- SETUP endp0 with ep_stall[0]=1, DATA0 with 8+2 bytes -> ep_setup=1, ep_commit, ACK; the next OUT on endp0 expects DATA1.
- OUT endp2 with ep_ready[2]=0 -> no ep_data_put, ep_abort, NAK; with ep_stall[2]=1 -> STALL.
- Token to addr 6 (dev_addr=5), endp 7 (NUM_EP=4), or corrupted data (rx_valid_packet=0) -> no ep_sel / ep_abort only, hs_req stays 0.
- OUT with no DATA for 1024 cycles -> IDLE, ep_sel=0; hold hs_grant low for 20 cycles -> hs_req/hs_pid stable; assert reset mid-DATA -> all outputs 0 immediately.
- With USB_OUT_SEQ_MAXPKT_CHECK_EN defined: 70-byte DATA0 -> 66 puts, ep_abort, no handshake; with the macro undefined -> 70 puts, ep_commit, ACK.
